// File: rtl/data_memory.sv
// Word-organised synchronous data RAM with programmable wait states for the Memory stage.
// Handles byte-lane steering, alignment and range checks; one access in flight at a time.
module data_memory #(
  parameter int N           = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_addr_vld,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_wr_en,
  input  logic [3:0]            i_sel,
  input  logic [N-1:0]          i_wdata,
  output logic                  o_ready,
  output logic                  o_d_valid,
  output logic [N-1:0]          o_rdata,
  output logic                  o_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int NB    = N / 8;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic                    wr_en;
  logic [3:0]              sel;
  logic [N-1:0]            wdata;

  logic [N-1:0]            mem [DEPTH_WORDS];

  logic [1:0]              lane;
  logic [IDX_W-1:0]        idx;
  logic                    out_of_range;
  logic                    misaligned;
  logic                    err_c;
  logic [3:0]              sel_eff;
  logic [N-1:0]            mask;
  logic [NB-1:0]           be;
  logic [N-1:0]            wshift;
  logic [N-1:0]            rword;
  logic                    commit;

  // Decode of the latched request; only consumed on the commit edge.
  always_comb begin
    lane         = addr[1:0];
    idx          = addr[IDX_W+1:2];
    out_of_range = (addr >> (IDX_W + 2)) != '0;
    sel_eff      = 4'b1111;
    mask         = '1;
    if (sel == 4'b0001) begin
      sel_eff = 4'b0001;
      mask    = N'(8'hFF);
    end else if (sel == 4'b0011) begin
      sel_eff = 4'b0011;
      mask    = N'(16'hFFFF);
    end
    misaligned = ((sel_eff == 4'b0011) && lane[0]) ||
                 ((sel_eff == 4'b1111) && (lane != 2'd0));
    err_c      = misaligned || out_of_range;
    be         = NB'(sel_eff) << lane;
    wshift     = wdata << {lane, 3'b000};
    rword      = (mem[idx] >> {lane, 3'b000}) & mask;
    commit     = (state == BUSY) && (cnt == '0);
  end

  // RAM contents are deliberately left out of reset; reset only suppresses the commit.
  always_ff @(posedge clk) begin
    if (rst_n && commit && wr_en && !err_c) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      wr_en     <= 1'b0;
      sel       <= '0;
      wdata     <= '0;
      o_ready   <= 1'b1;
      o_d_valid <= 1'b0;
      o_rdata   <= '0;
      o_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_addr_vld) begin
            addr    <= i_addr;
            wr_en   <= i_wr_en;
            sel     <= i_sel;
            wdata   <= i_wdata;
            cnt     <= 4'(WAIT_STATES - 1);
            state   <= BUSY;
            o_ready <= 1'b0;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state     <= DONE;
            o_d_valid <= 1'b1;
            o_err     <= err_c;
            o_rdata   <= (err_c || wr_en) ? '0 : rword;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          o_d_valid <= 1'b0;
          o_ready   <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: latency, byte/half/word steering, error cases, reset abort.
module tb_data_memory;

  localparam int WS = 2;

  logic        clk;
  logic        rst_n;
  logic        addr_vld;
  logic [31:0] addr;
  logic        wr_en;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ready;
  logic        d_valid;
  logic [31:0] rdata;
  logic        err;

  int checks;
  int failures;

  data_memory #(
    .N(32),
    .ADDR_WIDTH(32),
    .DEPTH_WORDS(1024),
    .WAIT_STATES(WS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_addr_vld(addr_vld),
    .i_addr    (addr),
    .i_wr_en   (wr_en),
    .i_sel     (sel),
    .i_wdata   (wdata),
    .o_ready   (ready),
    .o_d_valid (d_valid),
    .o_rdata   (rdata),
    .o_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction; inputs are scrambled after acceptance to prove they are latched.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [3:0] s, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    int lat;
    @(negedge clk);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    addr_vld = 1'b1;
    addr     = a;
    wr_en    = w;
    sel      = s;
    wdata    = wd;
    @(posedge clk);
    #1;
    addr_vld = 1'b0;
    addr     = 32'hFFFF_FFFF;
    wr_en    = ~w;
    sel      = 4'b0001;
    wdata    = 32'h5A5A_5A5A;
    lat = 0;
    rd  = 32'hXXXX_XXXX;
    er  = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      if (d_valid) begin
        lat = k;
        rd  = rdata;
        er  = err;
        break;
      end
      @(posedge clk);
      #1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(WS + 1));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(d_valid), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  int          dv_seen;

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    addr_vld = 1'b0;
    addr     = '0;
    wr_en    = 1'b0;
    sel      = 4'b1111;
    wdata    = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_dvalid", 32'(d_valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    access("st_w10", 1'b1, 32'h10, 4'b1111, 32'hDEAD_BEEF, rd, er);
    check("st_w10_err", 32'(er), 32'd0);
    access("ld_w10", 1'b0, 32'h10, 4'b1111, 32'h0, rd, er);
    check("ld_w10_data", rd, 32'hDEAD_BEEF);
    check("ld_w10_err", 32'(er), 32'd0);

    access("st_b12", 1'b1, 32'h12, 4'b0001, 32'h0000_00A5, rd, er);
    check("st_b12_err", 32'(er), 32'd0);
    access("ld_w10b", 1'b0, 32'h10, 4'b1111, 32'h0, rd, er);
    check("ld_w10b_data", rd, 32'hDEA5_BEEF);
    access("ld_b13", 1'b0, 32'h13, 4'b0001, 32'h0, rd, er);
    check("ld_b13_data", rd, 32'h0000_00DE);
    access("ld_h12", 1'b0, 32'h12, 4'b0011, 32'h0, rd, er);
    check("ld_h12_data", rd, 32'h0000_DEA5);
    access("ld_b11", 1'b0, 32'h11, 4'b0001, 32'h0, rd, er);
    check("ld_b11_data", rd, 32'h0000_00BE);
    access("ld_sel5", 1'b0, 32'h10, 4'b0101, 32'h0, rd, er);
    check("ld_sel5_data", rd, 32'hDEA5_BEEF);

    access("st_w14", 1'b1, 32'h14, 4'b1111, 32'h0, rd, er);
    access("st_h16", 1'b1, 32'h16, 4'b0011, 32'hFFFF_1234, rd, er);
    check("st_h16_err", 32'(er), 32'd0);
    access("ld_w14", 1'b0, 32'h14, 4'b1111, 32'h0, rd, er);
    check("ld_w14_data", rd, 32'h1234_0000);

    access("ld_h11", 1'b0, 32'h11, 4'b0011, 32'h0, rd, er);
    check("ld_h11_err", 32'(er), 32'd1);
    check("ld_h11_data", rd, 32'h0);
    access("st_w12mis", 1'b1, 32'h12, 4'b1111, 32'h1111_1111, rd, er);
    check("st_w12mis_err", 32'(er), 32'd1);
    access("ld_w10c", 1'b0, 32'h10, 4'b1111, 32'h0, rd, er);
    check("ld_w10c_data", rd, 32'hDEA5_BEEF);

    access("st_w00", 1'b1, 32'h0, 4'b1111, 32'h0102_0304, rd, er);
    access("st_oor", 1'b1, 32'h0000_1000, 4'b1111, 32'hFFFF_FFFF, rd, er);
    check("st_oor_err", 32'(er), 32'd1);
    access("ld_oor", 1'b0, 32'h0000_1000, 4'b1111, 32'h0, rd, er);
    check("ld_oor_err", 32'(er), 32'd1);
    check("ld_oor_data", rd, 32'h0);
    access("ld_w00", 1'b0, 32'h0, 4'b1111, 32'h0, rd, er);
    check("ld_w00_data", rd, 32'h0102_0304);
    check("ld_w00_err", 32'(er), 32'd0);

    // Reset while BUSY must abort the store and suppress the response.
    access("st_w20", 1'b1, 32'h20, 4'b1111, 32'hCAFE_F00D, rd, er);
    @(negedge clk);
    addr_vld = 1'b1;
    addr     = 32'h20;
    wr_en    = 1'b1;
    sel      = 4'b1111;
    wdata    = 32'h1234_5678;
    @(posedge clk);
    #1;
    addr_vld = 1'b0;
    check("abort_busy_ready", 32'(ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    dv_seen = 0;
    @(posedge clk);
    #1;
    if (d_valid) dv_seen++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      if (d_valid) dv_seen++;
      @(posedge clk);
      #1;
    end
    check("abort_no_dvalid", 32'(dv_seen), 32'd0);
    access("ld_w20", 1'b0, 32'h20, 4'b1111, 32'h0, rd, er);
    check("ld_w20_data", rd, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised synchronous data RAM that answers the Memory stage's data-memory interface: load/store address, byte select, write data in; read data and response valid out.
- Sits directly downstream of the Memory stage on its data-memory port.
- Programmable wait states model slow memory, so the Memory stage's stall path is exercised.
- Performs byte-lane steering, alignment and range checking.

Parameters:
- N, 32, data width in bits.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH_WORDS, 1024, number of N-bit words; power of two.
- WAIT_STATES, 2, cycles spent in BUSY before the response; legal range 1..15.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- i_addr_vld  in  1  request valid (load or store).
- i_addr  in  ADDR_WIDTH  byte address.
- i_wr_en  in  1  1 = store, 0 = load.
- i_sel  in  4  size select: 0001 = byte, 0011 = half, 1111 = word (lane 0 justified).
- i_wdata  in  N  store data, right-justified.
- o_ready  out  1  high in IDLE; a request is accepted only when o_ready=1.
- o_d_valid  out  1  one-cycle response pulse.
- o_rdata  out  N  load data, right-justified (byte/half in bits [7:0]/[15:0]); valid only with o_d_valid.
- o_err  out  1  misaligned or out-of-range access; valid only with o_d_valid.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, wait counter=0, latched request cleared.
  - o_d_valid=0, o_rdata=0, o_err=0, o_ready=1 from the next cycle.
  - RAM contents are not reset.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: if i_addr_vld, latch addr, wr_en, sel and wdata; counter=WAIT_STATES-1; go to BUSY.
  - BUSY: decrement counter. When counter==0, commit the access and go to DONE.
  - DONE: o_d_valid=1 for exactly this cycle, then go to IDLE. i_addr_vld is ignored in DONE; the requester drops or changes its request after seeing o_d_valid.
- Latency: request accepted at edge T gives o_d_valid high in cycle T+WAIT_STATES+1. Back-to-back throughput is one access per WAIT_STATES+2 cycles.
- Inputs are sampled only at acceptance. Changes to i_* while in BUSY or DONE have no effect.
- Outputs are registered and derive from state only. There is no combinational path from i_addr_vld to o_ready or o_d_valid.
- Addressing:
  - lane = addr[1:0].
  - word index = addr[log2(DEPTH_WORDS)+1:2].
  - Out of range: any address bit above the index range is nonzero.
- Alignment: error if sel=0011 and lane[0]=1, or sel=1111 and lane!=0. Byte accesses are always aligned.
- Store commit (BUSY->DONE edge):
  - Byte enables = sel << lane.
  - Write data = wdata << (8*lane).
  - Only enabled bytes change.
- Load commit: o_rdata = (word >> (8*lane)), masked to the sel width; upper bits zero. Sign extension is the Memory stage's job.
- Error (misaligned or out of range):
  - No RAM write.
  - o_rdata=0 and o_err=1 with o_d_valid.
  - The FSM still completes normally.
- Any sel other than 0001/0011 is treated as 1111.
- o_rdata and o_err hold their last values outside DONE; consumers qualify them with o_d_valid.
- Reset mid-operation (in BUSY): the access is aborted, a store is not committed, and no o_d_valid is produced.
- A store followed by a load to the same word returns the newly written data; there is no hazard because accesses are serialised.

Test Plan:
- Reset with WAIT_STATES=2: assert rst_n=0 for 2 cycles -> o_ready=1, o_d_valid=0, o_rdata=0, o_err=0.
- Word store then load: store addr 0x10, wdata 0xDEADBEEF, sel 1111 -> o_d_valid exactly 3 cycles after acceptance, o_err=0. Load addr 0x10 -> o_rdata=0xDEADBEEF.
- Byte store to lane 2: store addr 0x12, sel 0001, wdata 0x000000A5 over word 0xDEADBEEF -> word becomes 0xDEA5BEEF. Byte load addr 0x13 -> o_rdata=0x000000DE.
- Half access at lane 2: load addr 0x12, sel 0011 -> o_rdata=0x0000DEA5.
- Misaligned and out-of-range: half load addr 0x11 -> o_err=1, o_rdata=0. Word store to addr 0x00001000 (DEPTH_WORDS=1024) -> o_err=1, and a subsequent load of addr 0x0 is unchanged.
- Reset during BUSY: accept a word store addr 0x20 wdata 0x12345678, drop rst_n one cycle later -> no o_d_valid. A later load of addr 0x20 returns the prior contents, and o_ready=1 in the cycle after reset releases.
